// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, optional bypass,
// optional hardwired-zero R0 and a per-register busy scoreboard.
module regfile_mp_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic                     claim_err
);

    localparam int NREGS = 2**ADDR_W;
    localparam bit Z0    = (ZERO_R0 != 0);
    localparam bit BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_nxt;
    logic              cerr_q;
    logic              cerr_nxt;

    logic wr0_ok;
    logic wr1_ok;
    logic claim_ok;
    logic wr0_r0;
    logic wr1_r0;

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign wr0_r0 = Z0 && (wr0_addr == '0);
    assign wr1_r0 = Z0 && (wr1_addr == '0);

    // WP1 loses a same-register collision to WP0
    assign wr0_ok   = wr0_en && !wr0_r0;
    assign wr1_ok   = wr1_en && !wr1_r0
                   && !(wr0_en && (wr0_addr == wr1_addr));
    assign claim_ok = claim_en
                   && !(Z0 && (claim_addr == '0));

    // Array update; an edge while in reset discards pending writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    // Scoreboard next state: a claim beats a WP1 clear
    always_comb begin
        busy_nxt = busy_q;
        if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
        if (claim_ok) busy_nxt[claim_addr] = 1'b1;
    end

    // Double claim without a same-cycle release is an error
    always_comb begin
        cerr_nxt = claim_ok && busy_q[claim_addr]
                && !(wr1_en && (wr1_addr == claim_addr));
    end

    // Scoreboard and error pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cerr_q <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            cerr_q <= cerr_nxt;
        end
    end

    assign busy_vec  = busy_q;
    assign claim_err = cerr_q;

    // Read ports: zero R0, then WP0 bypass, WP1 bypass, array
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rv      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (Z0 && (ra == '0)) begin
                rv = '0;
            end else if (BYP && wr0_en && (wr0_addr == ra)) begin
                rv = wr0_data;
            end else if (BYP && wr1_en && (wr1_addr == ra)) begin
                rv = wr1_data;
            end else begin
                rv = regs[ra];
            end
            if (reset) begin
                rd_data[i*DATA_W +: DATA_W] = rv;
                rd_busy[i] = busy_q[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: one bypassing and one
// non-bypassing instance share the same directed stimulus.
module tb_regfile_mp_sb;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2;

    logic          clk;
    logic          reset;
    logic          wr0_en;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr1_en;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;
    logic          claim_en;
    logic [AW-1:0] claim_addr;
    logic [NR*AW-1:0] rd_addr;

    logic [NR*DW-1:0] rd_data_a;
    logic [NR-1:0]    rd_busy_a;
    logic [15:0]      busy_vec_a;
    logic             claim_err_a;
    logic [NR*DW-1:0] rd_data_b;
    logic [NR-1:0]    rd_busy_b;
    logic [15:0]      busy_vec_b;
    logic             claim_err_b;

    regfile_mp_sb #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
        .ZERO_R0(1), .BYPASS(1)
    ) u_a (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .busy_vec(busy_vec_a),
        .claim_err(claim_err_a)
    );

    regfile_mp_sb #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
        .ZERO_R0(1), .BYPASS(0)
    ) u_b (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .busy_vec(busy_vec_b),
        .claim_err(claim_err_b)
    );

    localparam logic [2:0] K_RDA = 3'd0;
    localparam logic [2:0] K_RDB = 3'd1;
    localparam logic [2:0] K_RBA = 3'd2;
    localparam logic [2:0] K_BVA = 3'd3;
    localparam logic [2:0] K_CEA = 3'd4;
    localparam logic [2:0] K_BVB = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [1:0]  idx;
        logic [15:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   n_chk;
    int   n_fail;
    bit   stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kname(logic [2:0] k);
        case (k)
            K_RDA:   return "rd_data_byp";
            K_RDB:   return "rd_data_nobyp";
            K_RBA:   return "rd_busy";
            K_BVA:   return "busy_vec";
            K_CEA:   return "claim_err";
            default: return "busy_vec_nobyp";
        endcase
    endfunction

    function automatic logic [15:0] actual(chk_t c);
        case (c.kind)
            K_RDA:   return rd_data_a[c.idx*DW +: DW];
            K_RDB:   return rd_data_b[c.idx*DW +: DW];
            K_RBA:   return {15'd0, rd_busy_a[c.idx]};
            K_BVA:   return busy_vec_a;
            K_CEA:   return {15'd0, claim_err_a};
            default: return busy_vec_b;
        endcase
    endfunction

    // Monitor: every negedge, compare whatever was queued
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = actual(c);
                n_chk++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s[%0d] @%0t: got %h expected %h",
                             kname(c.kind), c.idx, $time,
                             act, c.exp);
                end
            end
        end
    end

    task automatic push(logic [2:0] k, int i, logic [15:0] v);
        chk_t c;
        c.kind = k;
        c.idx  = 2'(i);
        c.exp  = v;
        sb_q.push_back(c);
    endtask

    task automatic exp_rd(int p, logic [15:0] va,
                          logic [15:0] vb);
        push(K_RDA, p, va);
        push(K_RDB, p, vb);
    endtask

    task automatic idle();
        wr0_en   = 1'b0;
        wr0_addr = '0;
        wr0_data = '0;
        wr1_en   = 1'b0;
        wr1_addr = '0;
        wr1_data = '0;
        claim_en = 1'b0;
        claim_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(int a1, int a0);
        rd_addr = {4'(a1), 4'(a0)};
    endtask

    task automatic w0(int a, logic [15:0] d);
        wr0_en = 1'b1; wr0_addr = 4'(a); wr0_data = d;
    endtask

    task automatic w1(int a, logic [15:0] d);
        wr1_en = 1'b1; wr1_addr = 4'(a); wr1_data = d;
    endtask

    task automatic claim(int a);
        claim_en = 1'b1; claim_addr = 4'(a);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        stim_done = 1'b0;
        idle();
        reset = 1'b0;
        rd(2, 1);
        next_cycle();
        // reset state
        rd(2, 1);
        exp_rd(0, 16'h0, 16'h0);
        exp_rd(1, 16'h0, 16'h0);
        push(K_BVA, 0, 16'h0);
        push(K_CEA, 0, 16'h0);
        next_cycle();
        // WP0 R1, then R2 back-to-back
        reset = 1'b1;
        rd(2, 1); w0(1, 16'hAAAA);
        exp_rd(0, 16'hAAAA, 16'h0000);
        exp_rd(1, 16'h0000, 16'h0000);
        next_cycle();
        rd(2, 1); w0(2, 16'h5555);
        exp_rd(0, 16'hAAAA, 16'hAAAA);
        exp_rd(1, 16'h5555, 16'h0000);
        next_cycle();
        rd(2, 1);
        exp_rd(0, 16'hAAAA, 16'hAAAA);
        exp_rd(1, 16'h5555, 16'h5555);
        next_cycle();
        // port collision on R3
        rd(3, 3); w0(3, 16'h1234); w1(3, 16'hBEEF);
        exp_rd(0, 16'h1234, 16'h0000);
        next_cycle();
        rd(3, 3);
        exp_rd(0, 16'h1234, 16'h1234);
        exp_rd(1, 16'h1234, 16'h1234);
        next_cycle();
        // R0 write and claim are ignored
        rd(0, 0); w0(0, 16'hFFFF); claim(0);
        exp_rd(0, 16'h0, 16'h0);
        next_cycle();
        rd(0, 0);
        exp_rd(0, 16'h0, 16'h0);
        push(K_BVA, 0, 16'h0);
        next_cycle();
        rd(0, 0);
        push(K_CEA, 0, 16'h0);
        // claim R5, no same-cycle rd_busy bypass
        rd(5, 5); claim(5);
        push(K_RBA, 0, 16'h0);
        push(K_BVA, 0, 16'h0);
        next_cycle();
        rd(5, 5);
        push(K_RBA, 0, 16'h1);
        push(K_RBA, 1, 16'h1);
        push(K_BVA, 0, 16'h0020);
        push(K_BVB, 0, 16'h0020);
        push(K_CEA, 0, 16'h0);
        next_cycle();
        // load return clears busy
        rd(5, 5); w1(5, 16'h00C3);
        exp_rd(0, 16'h00C3, 16'h0000);
        push(K_RBA, 0, 16'h1);
        next_cycle();
        rd(5, 5);
        exp_rd(0, 16'h00C3, 16'h00C3);
        push(K_RBA, 0, 16'h0);
        push(K_BVA, 0, 16'h0);
        next_cycle();
        // claim, then claim + clear together
        rd(5, 5); claim(5);
        next_cycle();
        rd(5, 5); claim(5); w1(5, 16'h0077);
        push(K_RBA, 0, 16'h1);
        push(K_CEA, 0, 16'h0);
        next_cycle();
        rd(5, 5);
        exp_rd(0, 16'h0077, 16'h0077);
        push(K_BVA, 0, 16'h0020);
        push(K_CEA, 0, 16'h0);
        next_cycle();
        // double claim of R6
        rd(6, 5); claim(6);
        next_cycle();
        rd(6, 5); claim(6);
        push(K_BVA, 0, 16'h0060);
        push(K_CEA, 0, 16'h0);
        next_cycle();
        rd(6, 5);
        push(K_CEA, 0, 16'h1);
        push(K_BVA, 0, 16'h0060);
        push(K_RBA, 1, 16'h1);
        next_cycle();
        rd(6, 5);
        push(K_CEA, 0, 16'h0);
        push(K_BVA, 0, 16'h0060);
        next_cycle();
        // reset mid-write: R7 write discarded
        rd(7, 5); w0(7, 16'hCAFE); claim(8);
        reset = 1'b0;
        exp_rd(0, 16'h0, 16'h0);
        exp_rd(1, 16'h0, 16'h0);
        push(K_RBA, 0, 16'h0);
        push(K_BVA, 0, 16'h0);
        push(K_CEA, 0, 16'h0);
        next_cycle();
        reset = 1'b1;
        rd(7, 5);
        exp_rd(0, 16'h0, 16'h0);
        exp_rd(1, 16'h0, 16'h0);
        push(K_BVA, 0, 16'h0);
        next_cycle();
        rd(3, 1);
        exp_rd(0, 16'h0, 16'h0);
        exp_rd(1, 16'h0, 16'h0);
        next_cycle();
        stim_done = 1'b1;
    end

    // End of run: drain queue, then summarise
    initial begin
        int t;
        t = 0;
        while (!stim_done && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (!stim_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: stimulus incomplete");
        end
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d left, expected 0",
                     sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
